// File: rtl/ram_lsu_ctrl.sv
// ram_lsu_ctrl: byte-addressed load/store front end for a word-wide data RAM.
// Sub-word stores are done as read-modify-write since the RAM has no byte enables.
module ram_lsu_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              iLSU_CLK,
    input  logic              iLSU_RST,
    input  logic              iREQ_VALID,
    output logic              oREQ_READY,
    input  logic              iREQ_WE,
    input  logic [1:0]        iREQ_SIZE,
    input  logic              iREQ_UNSIGNED,
    input  logic [ADDR_W+1:0] iREQ_ADDR,
    input  logic [31:0]       iREQ_WDATA,
    output logic              oRSP_VALID,
    input  logic              iRSP_READY,
    output logic [31:0]       oRSP_RDATA,
    output logic              oRSP_ERR,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic [31:0]       oRAM_DATA,
    input  logic [31:0]       iRAM_DATA
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_bad;
    logic [4:0]        lane_sh;
    logic [31:0]       rd_sh;
    logic [31:0]       lane_mask;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    // Reject reserved size and misaligned half/word accesses at accept time
    always_comb begin
        req_bad = 1'b0;
        unique case (iREQ_SIZE)
            2'b00: req_bad = 1'b0;
            2'b01: req_bad = iREQ_ADDR[0];
            2'b10: req_bad = |iREQ_ADDR[1:0];
            2'b11: req_bad = 1'b1;
        endcase
    end

    // Lane extraction and read-modify-write merge from the captured RAM word
    always_comb begin
        lane_sh   = {addr_q[1:0], 3'b000};
        rd_sh     = iRAM_DATA >> lane_sh;
        lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        merged    = (iRAM_DATA & ~(lane_mask << lane_sh))
                  | ((wdata_q & lane_mask) << lane_sh);
        load_val  = iRAM_DATA;
        unique case (size_q)
            2'b00: load_val = uns_q ? {24'd0, rd_sh[7:0]}
                                    : {{24{rd_sh[7]}}, rd_sh[7:0]};
            2'b01: load_val = uns_q ? {16'd0, rd_sh[15:0]}
                                    : {{16{rd_sh[15]}}, rd_sh[15:0]};
            default: load_val = iRAM_DATA;
        endcase
    end

    // Next-state and latch update for the single in-flight request
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (iREQ_VALID) begin
                    we_d    = iREQ_WE;
                    size_d  = iREQ_SIZE;
                    uns_d   = iREQ_UNSIGNED;
                    addr_d  = iREQ_ADDR;
                    wdata_d = iREQ_WDATA;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (iREQ_WE && iREQ_SIZE == 2'b10) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (we_q) begin
                    wdata_d = merged;
                    state_d = S_WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                if (iRSP_READY) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and request latches
    always_ff @(posedge iLSU_CLK or posedge iLSU_RST) begin
        if (iLSU_RST) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign oREQ_READY = (state_q == S_IDLE);
    assign oRSP_VALID = (state_q == S_RESP);
    assign oRSP_RDATA = rdata_q;
    assign oRSP_ERR   = err_q;
    assign oRAM_CE    = (state_q == S_READ) || (state_q == S_WRITE);
    assign oRAM_RD    = (state_q == S_READ);
    assign oRAM_WR    = (state_q == S_WRITE);
    assign oRAM_ADDR  = addr_q[ADDR_W+1:2];
    assign oRAM_DATA  = (state_q == S_WRITE) ? wdata_q : 32'd0;

endmodule

// File: tb/tb_ram_lsu_ctrl.sv
// tb_ram_lsu_ctrl: directed checks of ram_lsu_ctrl against a behavioural RAM.
// Expected values are hand-computed constants.
module tb_ram_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_ce;
    logic        ram_rd;
    logic        ram_wr;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    int n_cmp;
    int n_err;

    ram_lsu_ctrl #(.ADDR_W(8)) dut (
        .iLSU_CLK      (clk),
        .iLSU_RST      (rst),
        .iREQ_VALID    (req_valid),
        .oREQ_READY    (req_ready),
        .iREQ_WE       (req_we),
        .iREQ_SIZE     (req_size),
        .iREQ_UNSIGNED (req_uns),
        .iREQ_ADDR     (req_addr),
        .iREQ_WDATA    (req_wdata),
        .oRSP_VALID    (rsp_valid),
        .iRSP_READY    (rsp_ready),
        .oRSP_RDATA    (rsp_rdata),
        .oRSP_ERR      (rsp_err),
        .oRAM_CE       (ram_ce),
        .oRAM_RD       (ram_rd),
        .oRAM_WR       (ram_wr),
        .oRAM_ADDR     (ram_addr),
        .oRAM_DATA     (ram_wdata),
        .iRAM_DATA     (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on rising edge
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (ram_ce && ram_wr)
            mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [9:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_uns   = uns;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output int wr,
                            output int rd, output int ce);
        lat = 99;
        wr  = 0;
        rd  = 0;
        ce  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
            wr += int'(ram_wr);
            rd += int'(ram_rd);
            ce += int'(ram_ce);
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [9:0] a,
                          input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata,
                          output logic err, output int wr,
                          output int rd, output int ce);
        issue(we, sz, uns, a, wd);
        wait_rsp(lat, wr, rd, ce);
        rdata = rsp_rdata;
        err   = rsp_err;
        handshake();
        @(negedge clk);
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
    endtask

    int          lat, wr, rd, ce;
    logic [31:0] rdata;
    logic        err;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_uns   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_ce", 32'(ram_ce), 32'd0);
        chk("rst_rd", 32'(ram_rd), 32'd0);
        chk("rst_wr", 32'(ram_wr), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_data", ram_wdata, 32'd0);
        rst = 1'b0;

        // word store then word load
        do_txn(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF,
               lat, rdata, err, wr, rd, ce);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_wr_cycles", 32'(wr), 32'd1);
        chk("sw_rd_cycles", 32'(rd), 32'd0);
        chk("sw_rdata", rdata, 32'd0);
        chk("sw_err", 32'(err), 32'd0);
        chk("sw_mem4", mem[4], 32'hDEADBEEF);
        do_txn(1'b0, 2'b10, 1'b0, 10'h010, 32'h0,
               lat, rdata, err, wr, rd, ce);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        chk("lw_rd_cycles", 32'(rd), 32'd1);
        chk("lw_wr_cycles", 32'(wr), 32'd0);

        // sub-word stores: read-modify-write
        preload(8'd4, 32'h11223344);
        do_txn(1'b1, 2'b00, 1'b0, 10'h012, 32'hFFFFFFAB,
               lat, rdata, err, wr, rd, ce);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_rd_cycles", 32'(rd), 32'd1);
        chk("sb_wr_cycles", 32'(wr), 32'd1);
        chk("sb_mem4", mem[4], 32'h11AB3344);
        preload(8'd7, 32'hAAAABBBB);
        do_txn(1'b1, 2'b01, 1'b0, 10'h01E, 32'h55551234,
               lat, rdata, err, wr, rd, ce);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_mem7", mem[7], 32'h1234BBBB);

        // sub-word loads with sign/zero extension
        preload(8'd5, 32'h80FF7F01);
        do_txn(1'b0, 2'b00, 1'b0, 10'h015, 32'h0,
               lat, rdata, err, wr, rd, ce);
        chk("lb_015", rdata, 32'h0000007F);
        do_txn(1'b0, 2'b00, 1'b0, 10'h016, 32'h0,
               lat, rdata, err, wr, rd, ce);
        chk("lb_016", rdata, 32'hFFFFFFFF);
        do_txn(1'b0, 2'b00, 1'b1, 10'h017, 32'h0,
               lat, rdata, err, wr, rd, ce);
        chk("lbu_017", rdata, 32'h00000080);
        do_txn(1'b0, 2'b01, 1'b0, 10'h016, 32'h0,
               lat, rdata, err, wr, rd, ce);
        chk("lh_016", rdata, 32'hFFFF80FF);
        do_txn(1'b0, 2'b01, 1'b1, 10'h014, 32'h0,
               lat, rdata, err, wr, rd, ce);
        chk("lhu_014", rdata, 32'h00007F01);
        chk("lhu_lat", 32'(lat), 32'd2);

        // errors: misaligned word load, misaligned half store, reserved size
        do_txn(1'b0, 2'b10, 1'b0, 10'h011, 32'h0,
               lat, rdata, err, wr, rd, ce);
        chk("elw_lat", 32'(lat), 32'd1);
        chk("elw_err", 32'(err), 32'd1);
        chk("elw_rdata", rdata, 32'd0);
        chk("elw_ce", 32'(ce), 32'd0);
        do_txn(1'b1, 2'b01, 1'b0, 10'h013, 32'h0000CAFE,
               lat, rdata, err, wr, rd, ce);
        chk("esh_lat", 32'(lat), 32'd1);
        chk("esh_err", 32'(err), 32'd1);
        chk("esh_ce", 32'(ce), 32'd0);
        do_txn(1'b1, 2'b11, 1'b0, 10'h010, 32'h12345678,
               lat, rdata, err, wr, rd, ce);
        chk("esz_lat", 32'(lat), 32'd1);
        chk("esz_err", 32'(err), 32'd1);
        chk("esz_rdata", rdata, 32'd0);
        chk("esz_ce", 32'(ce), 32'd0);
        chk("err_mem4", mem[4], 32'h11AB3344);

        // response backpressure with a competing request held valid
        issue(1'b0, 2'b10, 1'b0, 10'h014, 32'h0);
        wait_rsp(lat, wr, rd, ce);
        chk("bp_lat", 32'(lat), 32'd2);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_uns   = 1'b0;
        req_addr  = 10'h010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'h80FF7F01);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        handshake();
        @(negedge clk);
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        chk("bp_idle_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp(lat, wr, rd, ce);
        chk("bp2_lat", 32'(lat), 32'd2);
        chk("bp2_rdata", rsp_rdata, 32'h11AB3344);
        handshake();

        // asynchronous reset in the read phase of a byte store
        preload(8'd6, 32'h55667788);
        issue(1'b1, 2'b00, 1'b0, 10'h018, 32'h00000000);
        @(negedge clk);
        chk("ar_in_read", 32'(ram_rd), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_ready", 32'(req_ready), 32'd1);
        chk("ar_ce", 32'(ram_ce), 32'd0);
        chk("ar_rd", 32'(ram_rd), 32'd0);
        chk("ar_wr", 32'(ram_wr), 32'd0);
        chk("ar_valid", 32'(rsp_valid), 32'd0);
        chk("ar_addr", 32'(ram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_mem6", mem[6], 32'h55667788);
        do_txn(1'b1, 2'b00, 1'b0, 10'h019, 32'h000000CC,
               lat, rdata, err, wr, rd, ce);
        chk("ar_sb_lat", 32'(lat), 32'd3);
        chk("ar_sb_mem6", mem[6], 32'h5566CC88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
